// File: rtl/alu_pkg.sv
// Shared opcode, state and class definitions for the integer execute unit.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned OP_W          = 5;
    localparam int unsigned OP_MULDIV_BIT = 4;
    localparam int unsigned OP_DIV_BIT    = 2;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD    = 5'h00,
        ALU_SUB    = 5'h01,
        ALU_AND    = 5'h02,
        ALU_OR     = 5'h03,
        ALU_XOR    = 5'h04,
        ALU_SRL    = 5'h05,
        ALU_SRA    = 5'h06,
        ALU_SLL    = 5'h07,
        ALU_SLT    = 5'h08,
        ALU_SLTU   = 5'h09,
        ALU_PASSB  = 5'h0E,
        ALU_PASSA  = 5'h0F,
        ALU_MUL    = 5'h10,
        ALU_MULH   = 5'h11,
        ALU_MULHSU = 5'h12,
        ALU_MULHU  = 5'h13,
        ALU_DIV    = 5'h14,
        ALU_DIVU   = 5'h15,
        ALU_REM    = 5'h16,
        ALU_REMU   = 5'h17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // True for the eight defined mul/div codes (0x10..0x17); 0x18..0x1F stay undefined.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return op[OP_MULDIV_BIT] && !op[3];
    endfunction

    // True for the four divide/remainder codes.
    function automatic logic is_div(input logic [OP_W-1:0] op);
        return is_muldiv(op) && op[OP_DIV_BIT];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 1-bit-per-cycle multiply (shift-add) and divide (restoring) with sign fix-up.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      sel,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  opnd;
    logic             div_mode;
    logic             sel_hi;
    logic             neg_q;
    logic             neg_r;

    logic             a_sgn_c, b_sgn_c, a_neg_c, b_neg_c;
    logic [XLEN-1:0]  ma_c, mb_c;
    logic [XLEN-1:0]  src_hi, src_lo, src_opnd, nxt_hi, nxt_lo;
    logic             src_div;
    logic [XLEN:0]    sum_c, rsh_c;
    logic [2*XLEN-1:0] prod_c, sprod_c;

    // Operand signedness and magnitudes (sel: MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU)
    always_comb begin
        a_sgn_c = sel[2] ? !sel[0] : (sel[1:0] != 2'b11);
        b_sgn_c = sel[2] ? !sel[0] : !sel[1];
        a_neg_c = a_sgn_c && a[XLEN-1];
        b_neg_c = b_sgn_c && b[XLEN-1];
        ma_c    = a_neg_c ? -a : a;
        mb_c    = b_neg_c ? -b : b;
    end

    // One iteration step; the first step is taken on the start cycle itself
    always_comb begin
        src_hi   = start ? '0 : hi;
        src_lo   = start ? (sel[2] ? ma_c : mb_c) : lo;
        src_opnd = start ? (sel[2] ? mb_c : ma_c) : opnd;
        src_div  = start ? sel[2] : div_mode;
        sum_c    = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_opnd} : '0);
        rsh_c    = {src_hi, src_lo[XLEN-1]};
        if (src_div) begin
            if (rsh_c >= {1'b0, src_opnd}) begin
                nxt_hi = XLEN'(rsh_c - {1'b0, src_opnd});
                nxt_lo = {src_lo[XLEN-2:0], 1'b1};
            end else begin
                nxt_hi = rsh_c[XLEN-1:0];
                nxt_lo = {src_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum_c[XLEN:1];
            nxt_lo = {sum_c[0], src_lo[XLEN-1:1]};
        end
    end

    // Accumulator, counter and sign bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            running  <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            sel_hi   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (start) begin
            hi       <= nxt_hi;
            lo       <= nxt_lo;
            opnd     <= src_opnd;
            div_mode <= sel[2];
            sel_hi   <= sel[2] ? sel[1] : (sel[1:0] != 2'b00);
            neg_q    <= a_neg_c ^ b_neg_c;
            neg_r    <= a_neg_c;
            cnt      <= CNT_W'(1);
            running  <= 1'b1;
            done     <= 1'b0;
        end else if (running) begin
            hi  <= nxt_hi;
            lo  <= nxt_lo;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    // Final sign fix-up and half/quotient/remainder select
    always_comb begin
        prod_c  = {hi, lo};
        sprod_c = neg_q ? -prod_c : prod_c;
        if (div_mode) begin
            result_c = sel_hi ? (neg_r ? -hi : hi) : (neg_q ? -lo : lo);
        end else begin
            result_c = sel_hi ? sprod_c[2*XLEN-1:XLEN] : sprod_c[XLEN-1:0];
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// EX-stage integer unit: single-cycle base ALU plus iterative mul/div behind valid/ready.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] input_a,
    input  logic [XLEN-1:0] input_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluout,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_e          state;
    logic [SHW-1:0]  shamt_c;
    logic [XLEN-1:0] base_c, imm_c, md_result_c;
    logic            div_zero_c, div_ovf_c, iter_c, start_c, md_done;

    // Single-cycle base ALU
    always_comb begin
        shamt_c = input_b[SHW-1:0];
        base_c  = '0;
        case (op)
            ALU_ADD:   base_c = input_a + input_b;
            ALU_SUB:   base_c = input_a - input_b;
            ALU_AND:   base_c = input_a & input_b;
            ALU_OR:    base_c = input_a | input_b;
            ALU_XOR:   base_c = input_a ^ input_b;
            ALU_SRL:   base_c = input_a >> shamt_c;
            ALU_SRA:   base_c = XLEN'($signed(input_a) >>> shamt_c);
            ALU_SLL:   base_c = input_a << shamt_c;
            ALU_SLT:   base_c = {{(XLEN-1){1'b0}}, $signed(input_a) < $signed(input_b)};
            ALU_SLTU:  base_c = {{(XLEN-1){1'b0}}, input_a < input_b};
            ALU_PASSB: base_c = input_b;
            ALU_PASSA: base_c = input_a;
            default:   base_c = '0;
        endcase
    end

    // Divide special cases resolve immediately; other mul/div ops go iterative
    always_comb begin
        div_zero_c = is_div(op) && (input_b == '0);
        div_ovf_c  = is_div(op) && !op[0] &&
                     (input_a == {1'b1, {(XLEN-1){1'b0}}}) && (input_b == '1);
        iter_c     = is_muldiv(op) && !div_zero_c && !div_ovf_c;
        start_c    = (state == IDLE) && in_valid && iter_c;
        if (div_zero_c) begin
            imm_c = op[1] ? input_a : '1;
        end else if (div_ovf_c) begin
            imm_c = op[1] ? '0 : input_a;
        end else begin
            imm_c = base_c;
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (start_c),
        .sel      (op[2:0]),
        .a        (input_a),
        .b        (input_b),
        .done     (md_done),
        .result_c (md_result_c)
    );

    // Control FSM and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            aluout    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (iter_c) begin
                            busy  <= 1'b1;
                            state <= BUSY;
                        end else begin
                            aluout    <= imm_c;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        aluout    <= md_result_c;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed plus randomized checks of alu_muldiv_seq against an arithmetic reference model.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluout;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [4:0] ops [22] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                             5'h08, 5'h09, 5'h0E, 5'h0F, 5'h10, 5'h11, 5'h12, 5'h13,
                             5'h14, 5'h15, 5'h16, 5'h17, 5'h0B, 5'h1C};

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .input_a   (input_a),
        .input_b   (input_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluout    (aluout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference result from RV32I/M rules using plain 64-bit and signed arithmetic
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb;
        int          ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ia = a;
        ib = b;
        case (o)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a & b;
            5'h03: return a | b;
            5'h04: return a ^ b;
            5'h05: return a >> b[4:0];
            5'h06: return 32'($signed(a) >>> b[4:0]);
            5'h07: return a << b[4:0];
            5'h08: return {31'b0, ia < ib};
            5'h09: return {31'b0, a < b};
            5'h0E: return b;
            5'h0F: return a;
            5'h10: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            5'h11: begin p = sa * sb; return p[63:32]; end
            5'h12: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            5'h13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'h14: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(ia / ib);
            end
            5'h15: return (b == 0) ? 32'hFFFFFFFF : a / b;
            5'h16: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            5'h17: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Expected acceptance-to-out_valid latency in cycles
    function automatic int model_lat(input logic [4:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        if (o >= 5'h10 && o <= 5'h13) return 33;
        if (o >= 5'h14 && o <= 5'h17) begin
            if (b == 0) return 1;
            if ((o == 5'h14 || o == 5'h16) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure latency, hold the result for `hold` cycles, then handshake
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp, held;
        int          exp_lat, lat, w;
        bit          bad_busy, bad_ready, bad_hold;
        exp     = model(o, a, b);
        exp_lat = model_lat(o, a, b);
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        chk({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
        op = o;
        input_a = a;
        input_b = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        bad_busy = 0;
        bad_ready = 0;
        while (!out_valid && lat < 100) begin
            if (busy !== (exp_lat > 1)) bad_busy = 1;
            if (in_ready !== 1'b0) bad_ready = 1;
            op = 5'($urandom);
            input_a = $urandom;
            input_b = $urandom;
            in_valid = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        chk({tag, ":out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":aluout"}, aluout, exp);
        chk({tag, ":busy_seq"}, 32'(bad_busy), 32'd0);
        chk({tag, ":in_ready_low"}, 32'(bad_ready | in_ready | busy), 32'd0);
        held = aluout;
        bad_hold = 0;
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            op = 5'($urandom);
            input_a = $urandom;
            step();
            if (aluout !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
                bad_hold = 1;
        end
        chk({tag, ":hold"}, 32'(bad_hold), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, ":out_valid_clr"}, 32'(out_valid), 32'd0);
        chk({tag, ":in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [4:0]  ro;
        bit          stale;
        clk = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 5'h0;
        input_a = 32'h0;
        input_b = 32'h0;
        repeat (2) step();
        chk("reset:in_ready", 32'(in_ready), 32'd1);
        chk("reset:out_valid", 32'(out_valid), 32'd0);
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:aluout", aluout, 32'h0);
        rst = 1'b0;
        step();

        run_op("add_ovf", 5'h00, 32'h7FFFFFFF, 32'h00000001, 3);
        run_op("sra", 5'h06, 32'h80000000, 32'h00000024, 0);
        run_op("srl", 5'h05, 32'h80000000, 32'h00000024, 0);
        run_op("slt", 5'h08, 32'hFFFFFFFF, 32'h00000001, 0);
        run_op("sltu", 5'h09, 32'hFFFFFFFF, 32'h00000001, 0);
        run_op("mul", 5'h10, 32'hFFFFFFFF, 32'h00000002, 1);
        run_op("mulh", 5'h11, 32'hFFFFFFFF, 32'h00000002, 1);
        run_op("mulhu", 5'h13, 32'hFFFFFFFF, 32'h00000002, 1);
        run_op("mulhsu", 5'h12, 32'hFFFFFFFF, 32'h00000002, 1);
        run_op("div_neg", 5'h14, 32'hFFFFFFF9, 32'h00000002, 0);
        run_op("rem_neg", 5'h16, 32'hFFFFFFF9, 32'h00000002, 0);
        run_op("divu_zero", 5'h15, 32'h00000007, 32'h00000000, 0);
        run_op("remu_zero", 5'h17, 32'h00000007, 32'h00000000, 0);
        run_op("div_ovf", 5'h14, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op("rem_ovf", 5'h16, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op("undef_0a", 5'h0A, 32'h12345678, 32'h9ABCDEF0, 0);
        run_op("undef_1f", 5'h1F, 32'h12345678, 32'h9ABCDEF0, 0);

        // Reset in the middle of a MULHU: no result may ever appear
        op = 5'h13;
        input_a = 32'hFFFFFFFF;
        input_b = 32'h00000002;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid:out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid:busy", 32'(busy), 32'd0);
        chk("rst_mid:in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (40) begin
            step();
            if (out_valid !== 1'b0) stale = 1;
        end
        chk("rst_mid:no_stale", 32'(stale), 32'd0);
        run_op("add_after_rst", 5'h00, 32'h00000002, 32'h00000003, 0);

        // Reset wins over a simultaneous request
        rst = 1'b1;
        op = 5'h00;
        input_a = 32'h1;
        input_b = 32'h1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_wins:in_ready", 32'(in_ready), 32'd1);
        step();
        chk("rst_wins:out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ro = ops[$urandom_range(0, 21)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 10)) - 32'd5; end
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%02h", i, ro), ro, ra, rb, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
